// File: rtl/hazard_pkg.sv
// hazard_pkg -- shared types and helpers for the pipeline hazard controller.
//
// Contents:
//   mdu_state_e  : MDU timer FSM state encoding (RUN, MDU_WAIT)
//   REG_ZERO     : architectural zero register index; never a real dependency
//   mdu_cnt_w()  : width of the MDU latency counter for a given latency
package hazard_pkg;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MDU_WAIT = 1'b1
  } mdu_state_e;

  localparam int REG_ZERO = 0;

  // The counter holds at most lat-1, which always fits in clog2(lat) bits.
  // A floor of 1 keeps the vector legal for the smallest latencies.
  function automatic int mdu_cnt_w(input int lat);
    int w;
    w = $clog2(lat);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/hazard_mdu_timer.sv
// hazard_mdu_timer -- tracks the in-flight multiply/divide operation.
//
// An MDU op entering EX loads a countdown of MDU_LAT-1; the unit reports busy
// until the countdown reaches 1, so busy lasts MDU_LAT-1 cycles after the
// start cycle. The countdown runs freely: pipeline stalls and flushes do not
// pause it.
//
// Ports:
//   clock        in   system clock, posedge
//   reset        in   synchronous active-high reset
//   ex_mdu_start in   MDU op entering EX this cycle
//   mdu_busy     out  HI/LO result still pending (state-derived, forced 0 in reset)
module hazard_mdu_timer
  import hazard_pkg::*;
#(
  parameter int MDU_LAT = 32
) (
  input  logic clock,
  input  logic reset,
  input  logic ex_mdu_start,
  output logic mdu_busy
);

  localparam int CNT_W = mdu_cnt_w(MDU_LAT);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MDU_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RUN: begin
        if (ex_mdu_start) begin
          state_d = MDU_WAIT;
          cnt_d   = CNT_LOAD;
        end
      end
      MDU_WAIT: begin
        // A second start while waiting should have been held off in ID; if it
        // slips through anyway, the newest op owns HI/LO, so restart the wait.
        if (ex_mdu_start) begin
          cnt_d = CNT_LOAD;
        end else if (cnt_q == CNT_LAST) begin
          // Leave the counter parked at 1 rather than decrementing to 0.
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - CNT_LAST;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // Output logic
  always_comb begin
    mdu_busy = (state_q == MDU_WAIT) && !reset;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- pipeline hazard controller for the 5-stage MIPS core.
//
// Drives the PC load enable, the IF/ID write enable and flush, and the ID/EX
// bubble mux. Stalls on load-use, on branch operands not yet available to the
// ID-stage compare, and on mfhi/mflo or a new MDU op while the MDU is busy.
// Taken branches flush IF/ID unless the delay-slot build is selected.
//
// Build option:
//   HAZARD_DELAY_SLOT_EN  defined: taken branch keeps the delay-slot
//                         instruction (ifid_flush stays 0).
//                         undefined: taken branch flushes IF/ID.
//
// Ports:
//   clock, reset                 system clock / synchronous active-high reset
//   id_rs, id_rt, id_uses_rt     ID source registers, rt-is-source flag
//   id_is_branch                 ID holds beq/bne
//   id_reads_hilo, id_mdu_op     ID holds mfhi/mflo, mult/div
//   branch_taken                 ID compare result
//   ex_mem_read, ex_reg_write    EX holds a load / writes the register file
//   ex_dst                       EX destination register
//   ex_mdu_start                 MDU op entering EX
//   mem_mem_read, mem_dst        MEM holds a load / its destination
//   pc_write, ifid_write         PC and IF/ID load enables
//   ifid_flush                   clear IF/ID to NOP
//   idex_bubble                  zero ID/EX control fields
//   mdu_busy                     MDU result pending
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MDU_LAT = 32,
  parameter int REG_AW  = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rt,
  input  logic              id_is_branch,
  input  logic              id_reads_hilo,
  input  logic              id_mdu_op,
  input  logic              branch_taken,
  input  logic              ex_mem_read,
  input  logic              ex_reg_write,
  input  logic [REG_AW-1:0] ex_dst,
  input  logic              ex_mdu_start,
  input  logic              mem_mem_read,
  input  logic [REG_AW-1:0] mem_dst,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic              mdu_busy
);

  localparam logic [REG_AW-1:0] ZERO_REG = REG_AW'(REG_ZERO);

  // True when a producer writing dst feeds either ID source. $zero is
  // hard-wired, so writes to it are never a dependency.
  function automatic logic src_hit(input logic [REG_AW-1:0] dst,
                                   input logic [REG_AW-1:0] rs,
                                   input logic [REG_AW-1:0] rt,
                                   input logic              uses_rt);
    logic rs_hit;
    logic rt_hit;
    rs_hit = (dst == rs);
    rt_hit = (dst == rt) && uses_rt;
    return (dst != ZERO_REG) && (rs_hit || rt_hit);
  endfunction

  logic ex_hit;
  logic mem_hit;
  logic load_use;
  logic br_ex;
  logic br_mem;
  logic mdu_hold;
  logic stall;
  logic taken_flush;

  hazard_mdu_timer #(
    .MDU_LAT (MDU_LAT)
  ) u_mdu_timer (
    .clock        (clock),
    .reset        (reset),
    .ex_mdu_start (ex_mdu_start),
    .mdu_busy     (mdu_busy)
  );

`ifdef HAZARD_DELAY_SLOT_EN
  assign taken_flush = 1'b0;
`else
  assign taken_flush = 1'b1;
`endif

  always_comb begin
    ex_hit   = src_hit(ex_dst, id_rs, id_rt, id_uses_rt);
    mem_hit  = src_hit(mem_dst, id_rs, id_rt, id_uses_rt);
    load_use = ex_mem_read && ex_hit;
    // The branch compares in ID, so any EX result (ALU or load) is too late,
    // and a load in MEM has not returned its data yet.
    br_ex    = id_is_branch && ex_reg_write && ex_hit;
    br_mem   = id_is_branch && mem_mem_read && mem_hit;
    mdu_hold = mdu_busy && (id_reads_hilo || id_mdu_op);
    stall    = load_use || br_ex || br_mem || mdu_hold;
  end

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (reset) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (stall) begin
      // branch_taken is ignored here: it was computed from stale operands.
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end else if (branch_taken) begin
      ifid_flush  = taken_flush;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  localparam int MDU_LAT = 4;
  localparam int REG_AW  = 5;

  // {pc_write, ifid_write, ifid_flush, idex_bubble}
  localparam logic [3:0] RUNV   = 4'b1100;
  localparam logic [3:0] STALLV = 4'b0001;
  localparam logic [3:0] RSTV   = 4'b0011;
`ifdef HAZARD_DELAY_SLOT_EN
  localparam logic [3:0] TAKENV = 4'b1100;
`else
  localparam logic [3:0] TAKENV = 4'b1110;
`endif

  logic              clock = 1'b0;
  logic              reset;
  logic [REG_AW-1:0] id_rs, id_rt, ex_dst, mem_dst;
  logic              id_uses_rt, id_is_branch, id_reads_hilo, id_mdu_op;
  logic              branch_taken, ex_mem_read, ex_reg_write, ex_mdu_start;
  logic              mem_mem_read;
  logic              pc_write, ifid_write, ifid_flush, idex_bubble, mdu_busy;
  logic [3:0]        outv;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  hazard_ctrl #(
    .MDU_LAT (MDU_LAT),
    .REG_AW  (REG_AW)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_uses_rt    (id_uses_rt),
    .id_is_branch  (id_is_branch),
    .id_reads_hilo (id_reads_hilo),
    .id_mdu_op     (id_mdu_op),
    .branch_taken  (branch_taken),
    .ex_mem_read   (ex_mem_read),
    .ex_reg_write  (ex_reg_write),
    .ex_dst        (ex_dst),
    .ex_mdu_start  (ex_mdu_start),
    .mem_mem_read  (mem_mem_read),
    .mem_dst       (mem_dst),
    .pc_write      (pc_write),
    .ifid_write    (ifid_write),
    .ifid_flush    (ifid_flush),
    .idex_bubble   (idex_bubble),
    .mdu_busy      (mdu_busy)
  );

  assign outv = {pc_write, ifid_write, ifid_flush, idex_bubble};

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    reset         = 1'b0;
    id_rs         = '0;
    id_rt         = '0;
    ex_dst        = '0;
    mem_dst       = '0;
    id_uses_rt    = 1'b0;
    id_is_branch  = 1'b0;
    id_reads_hilo = 1'b0;
    id_mdu_op     = 1'b0;
    branch_taken  = 1'b0;
    ex_mem_read   = 1'b0;
    ex_reg_write  = 1'b0;
    ex_mdu_start  = 1'b0;
    mem_mem_read  = 1'b0;
  endtask

  // Advance to just after the next rising edge, then clear inputs for the
  // new cycle; callers set this cycle's inputs and call settle() before checks.
  task automatic tick();
    @(posedge clock);
    #1;
    idle();
  endtask

  task automatic settle();
    #2;
  endtask

  // Check both the control outputs and mdu_busy for the current cycle.
  task automatic chk_cyc(input string tag, input logic [3:0] exp_out, input logic exp_busy);
    chk({tag, ".out"}, {4'h0, outv}, {4'h0, exp_out});
    chk({tag, ".busy"}, {7'h0, mdu_busy}, {7'h0, exp_busy});
  endtask

  initial begin
    idle();
    reset = 1'b1;
    settle();
    chk_cyc("reset0", RSTV, 1'b0);
    tick(); reset = 1'b1; settle();
    chk_cyc("reset1", RSTV, 1'b0);

    tick(); settle();
    chk_cyc("run_idle", RUNV, 1'b0);

    // lw $2 in EX, add using $2 in ID
    tick(); ex_mem_read = 1'b1; ex_dst = 5'd2; id_rs = 5'd2; settle();
    chk_cyc("load_use", STALLV, 1'b0);
    tick(); id_rs = 5'd2; settle();
    chk_cyc("load_use_after", RUNV, 1'b0);

    // $zero never matches
    tick(); ex_mem_read = 1'b1; ex_dst = 5'd0; id_rs = 5'd0; settle();
    chk_cyc("zero_reg", RUNV, 1'b0);

    // rt only counts when it is a source
    tick(); ex_mem_read = 1'b1; ex_dst = 5'd5; id_rt = 5'd5; id_rs = 5'd1; settle();
    chk_cyc("rt_unused", RUNV, 1'b0);
    tick(); ex_mem_read = 1'b1; ex_dst = 5'd5; id_rt = 5'd5; id_rs = 5'd1;
    id_uses_rt = 1'b1; settle();
    chk_cyc("rt_used", STALLV, 1'b0);

    // ALU result in EX is fine for a non-branch consumer
    tick(); ex_reg_write = 1'b1; ex_dst = 5'd3; id_rs = 5'd3; settle();
    chk_cyc("alu_fwd", RUNV, 1'b0);

    // beq with rt produced in EX, taken ignored while stalled
    tick(); id_is_branch = 1'b1; id_rt = 5'd3; id_uses_rt = 1'b1;
    ex_reg_write = 1'b1; ex_dst = 5'd3; branch_taken = 1'b1; settle();
    chk_cyc("br_ex", STALLV, 1'b0);
    tick(); id_is_branch = 1'b1; id_rt = 5'd3; id_uses_rt = 1'b1;
    branch_taken = 1'b1; settle();
    chk_cyc("br_taken", TAKENV, 1'b0);

    // branch reading a load result still in MEM
    tick(); id_is_branch = 1'b1; id_rs = 5'd4; mem_mem_read = 1'b1; mem_dst = 5'd4; settle();
    chk_cyc("br_mem", STALLV, 1'b0);

    // stall wins over taken
    tick(); ex_mem_read = 1'b1; ex_dst = 5'd7; id_rs = 5'd7; branch_taken = 1'b1; settle();
    chk_cyc("stall_vs_taken", STALLV, 1'b0);

    // MDU op with MDU_LAT=4: busy for 3 cycles after the start cycle
    tick(); ex_mdu_start = 1'b1; settle();
    chk_cyc("mdu_start", RUNV, 1'b0);
    tick(); id_mdu_op = 1'b1; settle();
    chk_cyc("mdu_b1_op", STALLV, 1'b1);
    tick(); id_reads_hilo = 1'b1; settle();
    chk_cyc("mdu_b2_mflo", STALLV, 1'b1);
    tick(); id_reads_hilo = 1'b1; settle();
    chk_cyc("mdu_b3_mflo", STALLV, 1'b1);
    tick(); id_reads_hilo = 1'b1; settle();
    chk_cyc("mdu_done_mflo", RUNV, 1'b0);

    // countdown keeps running under an unrelated stall; busy alone does not stall
    tick(); ex_mdu_start = 1'b1; settle();
    chk_cyc("mdu2_start", RUNV, 1'b0);
    tick(); settle();
    chk_cyc("mdu2_b1_nodep", RUNV, 1'b1);
    tick(); ex_mem_read = 1'b1; ex_dst = 5'd9; id_rs = 5'd9; settle();
    chk_cyc("mdu2_b2_lu", STALLV, 1'b1);
    tick(); settle();
    chk_cyc("mdu2_b3", RUNV, 1'b1);
    tick(); settle();
    chk_cyc("mdu2_done", RUNV, 1'b0);

    // reset during the 2nd busy cycle
    tick(); ex_mdu_start = 1'b1; settle();
    chk_cyc("mdu3_start", RUNV, 1'b0);
    tick(); id_reads_hilo = 1'b1; settle();
    chk_cyc("mdu3_b1", STALLV, 1'b1);
    tick(); reset = 1'b1; id_reads_hilo = 1'b1; settle();
    chk_cyc("mdu3_reset", RSTV, 1'b0);
    tick(); id_reads_hilo = 1'b1; settle();
    chk_cyc("mdu3_post_rst", RUNV, 1'b0);
    tick(); id_reads_hilo = 1'b1; settle();
    chk_cyc("mdu3_post_rst2", RUNV, 1'b0);

    // a second start while busy restarts the full wait
    tick(); ex_mdu_start = 1'b1; settle();
    chk_cyc("mdu4_start", RUNV, 1'b0);
    tick(); ex_mdu_start = 1'b1; settle();
    chk_cyc("mdu4_restart", RUNV, 1'b1);
    tick(); settle();
    chk_cyc("mdu4_r1", RUNV, 1'b1);
    tick(); settle();
    chk_cyc("mdu4_r2", RUNV, 1'b1);
    tick(); settle();
    chk_cyc("mdu4_r3", RUNV, 1'b1);
    tick(); settle();
    chk_cyc("mdu4_done", RUNV, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
